// File: rtl/mult_div_unit.sv
// mult_div_unit
// Multi-cycle multiply/divide unit for the E stage. Owns the architectural
// HI/LO registers, accepts one operation per start pulse and reports
// occupancy through busy so the D-stage stall logic can hold the pipeline.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   reset  - asynchronous active-low reset, clears all state
//   start  - one-cycle issue strobe for an MD-class instruction
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A, B   - forwarded rs / rt operands
//   busy   - multi-cycle operation in progress (registered)
//   hi, lo - architectural HI / LO
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,  // legal range 1..31
    parameter int unsigned DIV_CYCLES  = 10  // legal range 1..31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } op_e;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] pend_q;
    logic        pend_ok_q;   // pending result is committed at the end of RUN
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] result_d;
    logic        commit_d;
    logic [4:0]  cnt_d;

    logic [63:0]        sext_a;
    logic [63:0]        sext_b;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    // Arithmetic is evaluated in the issue cycle; the RUN phase only models
    // latency, so the result is captured into pend_q at the start edge.
    always_comb begin
        sext_a = {{32{A[31]}}, A};
        sext_b = {{32{B[31]}}, B};
        // Low 64 bits of the sign-extended product are the exact signed product.
        prod_s = sext_a * sext_b;
        prod_u = {32'h0, A} * {32'h0, B};

        sa = $signed(A);
        sb = $signed(B);
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (B != 32'h0) begin
            // Most-negative / -1 overflows the signed quotient; pin the
            // wrapped result explicitly rather than rely on tool behaviour.
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quo_s = 32'h8000_0000;
                rem_s = '0;
            end else begin
                quo_s = sa / sb;
                rem_s = sa % sb;
            end
            quo_u = A / B;
            rem_u = A % B;
        end

        result_d = '0;
        commit_d = 1'b1;
        cnt_d    = MULT_LOAD;
        case (op_e'(op))
            OP_MULT:  result_d = prod_s;
            OP_MULTU: result_d = prod_u;
            OP_DIV: begin
                result_d = {rem_s, quo_s};
                commit_d = (B != 32'h0);
                cnt_d    = DIV_LOAD;
            end
            OP_DIVU: begin
                result_d = {rem_u, quo_u};
                commit_d = (B != 32'h0);
                cnt_d    = DIV_LOAD;
            end
            default: begin
                result_d = '0;
                commit_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_ok_q <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_e'(op))
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pend_q    <= result_d;
                                pend_ok_q <= commit_d;
                                cnt_q     <= cnt_d;
                                busy_q    <= 1'b1;
                                state_q   <= RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start is ignored here; the stall logic never issues it.
                    if (cnt_q == 5'd0) begin
                        if (pend_ok_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Directed and randomized checks of mult_div_unit against an arithmetic
// reference model of HI/LO and busy duration.
module tb_mult_div_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned checks;
    int unsigned passes;
    int unsigned fails;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: architectural effect of one operation on HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {exp_hi, exp_lo} = p;
            end
            3'd1: begin
                pu = {32'h0, a} * {32'h0, b};
                {exp_hi, exp_lo} = pu;
            end
            3'd2: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                exp_lo = q[31:0];
                exp_hi = r[31:0];
            end
            3'd3: if (b != 0) begin
                exp_lo = a / b;
                exp_hi = a % b;
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Single-edge ops (MTHI/MTLO/no-op): visible one edge after start, no busy.
    task automatic issue_simple(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        model(o, a, b);
        check("simple_busy", {63'h0, busy}, 64'h0);
        check("simple_hi", {32'h0, hi}, {32'h0, exp_hi});
        check("simple_lo", {32'h0, lo}, {32'h0, exp_lo});
    endtask

    // Multi-cycle op; optionally injects an illegal MTLO start during RUN.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int n;
        int expn;
        expn = (o < 3'd2) ? int'(MC) : int'(DC);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("md_busy_rise", {63'h0, busy}, 64'h1);
        check("md_hold_hilo", {hi, lo}, {exp_hi, exp_lo});
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            if (inject && n == 2) begin
                start = 1'b1; op = 3'd5; A = 32'hDEAD; B = 32'h0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        model(o, a, b);
        check("md_busy_cycles", 64'(n), 64'(expn));
        check("md_hi", {32'h0, hi}, {32'h0, exp_hi});
        check("md_lo", {32'h0, lo}, {32'h0, exp_lo});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0; passes = 0; fails = 0;
        exp_hi = '0; exp_lo = '0;
        reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Signed / unsigned multiply
        run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_x3", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // Signed / unsigned divide
        run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_7_2", {hi, lo}, 64'h0000_0001_0000_0003);

        // Overflow corner
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        // Divide by zero leaves HI/LO untouched
        issue_simple(3'd4, 32'h11, 32'h0);
        issue_simple(3'd5, 32'h22, 32'h0);
        run_md(3'd3, 32'd5, 32'd0, 1'b0);
        check("divz_keep", {hi, lo}, 64'h0000_0011_0000_0022);

        // Asynchronous reset mid-RUN, away from any clock edge
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        check("async_rst_hilo", {hi, lo}, 64'h0);
        exp_hi = '0; exp_lo = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Start during RUN is ignored
        run_md(3'd0, 32'd3, 32'd4, 1'b1);
        check("ignore_busy", {hi, lo}, 64'h0000_0000_0000_000C);

        // Back-to-back in the first IDLE cycle
        run_md(3'd1, 32'd2, 32'd3, 1'b0);
        check("b2b_mul_lo", {32'h0, lo}, 64'd6);
        run_md(3'd3, 32'd9, 32'd4, 1'b0);
        check("b2b_div", {hi, lo}, 64'h0000_0001_0000_0002);

        // Randomized mix against the model
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (ro < 3'd4) run_md(ro, ra, rb, 1'b0);
            else issue_simple(ro, ra, rb);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. It owns the HI/LO registers, accepts one operation per `start` pulse, and reports occupancy through `busy`. The hazard/stall logic in D consumes `busy`, holding PC and the D register and clearing E while the unit is occupied. `start` itself needs no internal rejection path because the stall logic guarantees it never arrives while `busy` is high.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU; legal range 1–31.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU; legal range 1–31.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low; 0 clears all state immediately.
- `start` input, 1 bit: one-cycle issue strobe from E for an MD instruction.
- `op` input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 no-op.
- `A` input, 32 bits: forwarded rs value in E.
- `B` input, 32 bits: forwarded rt value in E.
- `busy` output, 1 bit: multi-cycle operation in progress.
- `hi` output, 32 bits: architectural HI, read by MFHI.
- `lo` output, 32 bits: architectural LO, read by MFLO.

## Operation
- State machine states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; a 5-bit down-counter is loaded with the cycle count; a pending 64-bit result is held.
- IDLE, `start`=1, op 0–3:
  - Compute the result from `A` and `B` at the same edge and store it in the pending register.
  - Load the counter with `MULT_CYCLES`-1 or `DIV_CYCLES`-1.
  - Go to RUN.
- IDLE, `start`=1, op 4: `hi` <= `A` at the edge; stay IDLE; `busy` stays 0.
- IDLE, `start`=1, op 5: `lo` <= `A` at the edge; stay IDLE; `busy` stays 0.
- IDLE, `start`=1, op 6–7: no state change.
- RUN:
  - Counter decrements each cycle.
  - On the edge where the counter reads 0, commit the pending result to `hi`/`lo` and return to IDLE.
- `start` sampled in RUN (any op) is ignored. This is a protocol violation; the stall logic forbids it.
- Arithmetic:
  - MULT: {hi,lo} = $signed(A)*$signed(B), full 64-bit product.
  - MULTU: {hi,lo} = A*B, unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (Verilog signed / and %).
  - DIVU: unsigned quotient to lo, unsigned remainder to hi.
  - Divide with B=0: no commit; `hi`/`lo` keep their prior values; `busy` timing is unchanged (full `DIV_CYCLES`).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset (`reset`=0), including mid-RUN:
  - `busy`=0, `hi`=0, `lo`=0, counter=0, state=IDLE.
  - The pending result is discarded.
- Consumer contract:
  - The stall logic stalls any MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo) in D while `busy`=1 or `start`=1.
  - The unit relies on this; it neither queues nor forwards.

## Timing
- `start` sampled at edge k with op 0–3:
  - `busy`=1 from just after edge k until edge k+N, where N is the cycle parameter.
  - `hi`/`lo` take the result at edge k+N.
  - `busy`=0 immediately after edge k+N.
  - `busy` is therefore high for exactly N cycles.
- `busy` is registered; it does not combinationally follow `start`.
- MTHI/MTLO: visible on `hi`/`lo` one edge after `start`; zero busy cycles.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after commit, i.e. sampled at edge k+N+1.
- `hi`/`lo` hold their old values throughout RUN; MFHI/MFLO are never issued then.
- Asynchronous reset takes effect without a clock edge; release is synchronous to the next edge.

## Test plan
- Reset: assert `reset`=0 mid-operation -> `busy`=0, `hi`=`lo`=0 immediately; a later `start` behaves normally.
- MULT with A=0xFFFFFFFE (-2), B=3 -> `busy` high 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV with A=-7 (0xFFFFFFF9), B=2 -> `busy` high 10 cycles; then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU with A=7, B=2 -> `lo`=3, `hi`=1.
- Divide by zero: preload via MTHI 0x11, MTLO 0x22, then DIVU A=5, B=0 -> `busy` high 10 cycles; `hi`=0x11, `lo`=0x22 unchanged.
- Ignore while busy: MULT 3×4, then `start` with MTLO A=0xDEAD at cycle 2 of RUN -> ignored; `lo`=12, `hi`=0 at commit; `busy` drops on schedule.
- Back-to-back: MULTU 2×3 then DIVU 9/4 issued in the first IDLE cycle -> `lo`=6 after 5 cycles; `busy` re-asserts the next edge; `lo`=2, `hi`=1 after 10 more cycles.
